rcc_ker_clk_switch_ctrl: RTL

//  Sequencer for a kernel-clock source switch (RTC/LPTIM-class) with N sources.

---
 rtl/rcc_ker_clk_switch_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rcc_ker_clk_switch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rcc_ker_clk_switch_ctrl                                    |
// | Description : Kernel-clock source switch sequencer with CSS fallback     |
// |               and ready timeout, driving a glitch-free mux and gate.     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module rcc_ker_clk_switch_ctrl #(
    parameter int unsigned          SRC_NUM   = 4,
    parameter int unsigned          SEL_W     = 2,
    parameter int unsigned          SAFE_SRC  = 0,
    parameter logic [SRC_NUM-1:0]   FAIL_MASK = 4'b0010,
    parameter int unsigned          OFF_CYC   = 4,
    parameter int unsigned          ON_CYC    = 2,
    parameter int unsigned          RDY_TMO   = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    sel_req,
    input  logic                en_req,
    input  logic [SRC_NUM-1:0]  src_rdy,
    input  logic [SRC_NUM-1:0]  src_fail,
    input  logic                fail_clr,
    input  logic                testmode,
    output logic [SEL_W-1:0]    mux_sel,
    output logic                gate_en,
    output logic                busy,
    output logic                fail_flag,
    output logic                sel_err
);

    localparam int unsigned c_max_ab  = (OFF_CYC > ON_CYC) ? OFF_CYC : ON_CYC;
    localparam int unsigned c_cnt_top = (c_max_ab > RDY_TMO) ? c_max_ab : RDY_TMO;
    localparam int unsigned c_cnt_w   = $clog2(c_cnt_top + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(c_cnt_top);
    localparam logic [c_cnt_w-1:0] c_off_last = c_cnt_w'(OFF_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_on_last  = c_cnt_w'(ON_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(RDY_TMO - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

    localparam logic [SEL_W-1:0]   c_safe_sel  = SEL_W'(SAFE_SRC);
    localparam logic [SRC_NUM-1:0] c_safe_bit  = SRC_NUM'(1) << SAFE_SRC;
    // The safe source is never allowed to raise a CSS fallback.
    localparam logic [SRC_NUM-1:0] c_fail_mask = FAIL_MASK & ~c_safe_bit;

    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_gate_off = 2'd1;
    localparam logic [1:0] c_st_wait_rdy = 2'd2;
    localparam logic [1:0] c_st_gate_on  = 2'd3;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [SEL_W-1:0]   r_tgt;
    logic [SEL_W-1:0]   r_mux_sel;
    logic               r_gate_en;
    logic               r_busy;
    logic               r_fail_flag;
    logic               r_sel_err;

    logic               w_rdy_cur;
    logic               w_rdy_tgt;
    logic               w_css;
    logic               w_req_ok;
    logic [c_cnt_w-1:0] w_cnt_inc;

    function automatic logic f_rdy(input logic [SEL_W-1:0]   idx,
                                   input logic [SRC_NUM-1:0] vec);
        logic v;
        v = 1'b0;
        for (int unsigned i = 0; i < SRC_NUM; i++) begin
            if (idx == SEL_W'(i)) begin
                v = vec[i] | c_safe_bit[i];
            end
        end
        return v;
    endfunction

    function automatic logic f_fail(input logic [SEL_W-1:0]   idx,
                                    input logic [SRC_NUM-1:0] vec);
        logic v;
        v = 1'b0;
        for (int unsigned i = 0; i < SRC_NUM; i++) begin
            if (idx == SEL_W'(i)) begin
                v = vec[i] & c_fail_mask[i];
            end
        end
        return v;
    endfunction

    always_comb begin
        w_rdy_cur = f_rdy(r_mux_sel, src_rdy);
        w_rdy_tgt = f_rdy(r_tgt, src_rdy);
        w_css     = f_fail(r_mux_sel, src_fail);
        w_req_ok  = (sel_req != r_mux_sel) && (32'(sel_req) < SRC_NUM)
                    && !r_fail_flag;
        w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_run;
            r_cnt       <= c_cnt_zero;
            r_tgt       <= c_safe_sel;
            r_mux_sel   <= c_safe_sel;
            r_gate_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_fail_flag <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            if (w_css) begin
                r_fail_flag <= 1'b1;
            end else if (fail_clr) begin
                r_fail_flag <= 1'b0;
            end

            // A clock failure restarts the sequence toward the safe source
            // from whatever state we are in.
            if (w_css) begin
                r_state   <= c_st_gate_off;
                r_cnt     <= c_cnt_zero;
                r_tgt     <= c_safe_sel;
                r_gate_en <= 1'b0;
                r_busy    <= 1'b1;
            end else begin
                case (r_state)
                    c_st_run: begin
                        if (w_req_ok) begin
                            r_state   <= c_st_gate_off;
                            r_cnt     <= c_cnt_zero;
                            r_tgt     <= sel_req;
                            r_sel_err <= 1'b0;
                            r_gate_en <= 1'b0;
                            r_busy    <= 1'b1;
                        end else begin
                            r_gate_en <= en_req & w_rdy_cur;
                        end
                    end
                    c_st_gate_off: begin
                        if (r_cnt >= c_off_last) begin
                            r_state   <= c_st_wait_rdy;
                            r_cnt     <= c_cnt_zero;
                            r_mux_sel <= r_tgt;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    c_st_wait_rdy: begin
                        if (w_rdy_tgt) begin
                            r_state <= c_st_gate_on;
                            r_cnt   <= c_cnt_zero;
                        end else if (r_cnt >= c_tmo_last) begin
                            r_state   <= c_st_gate_on;
                            r_cnt     <= c_cnt_zero;
                            r_sel_err <= 1'b1;
                            r_tgt     <= c_safe_sel;
                            r_mux_sel <= c_safe_sel;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    c_st_gate_on: begin
                        if (r_cnt >= c_on_last) begin
                            r_state <= c_st_run;
                            r_cnt   <= c_cnt_zero;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= c_st_run;
                        r_cnt   <= c_cnt_zero;
                    end
                endcase
            end
        end
    end

    assign mux_sel   = r_mux_sel;
    assign gate_en   = testmode | r_gate_en;
    assign busy      = r_busy;
    assign fail_flag = r_fail_flag;
    assign sel_err   = r_sel_err;

endmodule
`default_nettype wire
